// File: rtl/alu_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and the shared ALU.
// The arbiter takes the slave view; a requester/ALU environment takes the master view.
interface alu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [4:0]  req0_shamt;
    logic [3:0]  req0_op;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [4:0]  req1_shamt;
    logic [3:0]  req1_op;
    logic        rsp0_valid;
    logic        rsp0_ready;
    logic [31:0] rsp0_result;
    logic        rsp0_ovf;
    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [31:0] rsp1_result;
    logic        rsp1_ovf;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_shamt;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        alu_ovf;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_shamt, req0_op,
        input  req1_valid, req1_a, req1_b, req1_shamt, req1_op,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_result, rsp0_ovf,
        output rsp1_valid, rsp1_result, rsp1_ovf,
        input  rsp0_ready, rsp1_ready,
        output alu_a, alu_b, alu_shamt, alu_ctrl,
        input  alu_result, alu_ovf
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_shamt, req0_op,
        output req1_valid, req1_a, req1_b, req1_shamt, req1_op,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_result, rsp0_ovf,
        input  rsp1_valid, rsp1_result, rsp1_ovf,
        output rsp0_ready, rsp1_ready,
        input  alu_a, alu_b, alu_shamt, alu_ctrl,
        output alu_result, alu_ovf
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Each operation runs IDLE -> EXEC -> RESP; priority flips to the other side after every response.
module alu_arbiter #(
    parameter bit RR_INIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_arbiter_if.slave      io_arb,
    output logic              o_busy,
    output logic [15:0]       o_ops_done
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]  r_state;
    logic        r_prio;
    logic        r_owner;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [4:0]  r_shamt;
    logic [3:0]  r_op;
    logic [31:0] r_result;
    logic        r_ovf;
    logic        r_busy;
    logic [15:0] r_ops_done;

    logic        w_win;
    logic        w_grant0;
    logic        w_grant1;
    logic        w_accept;
    logic        w_rsp_hs;

    // Winner selection and grant/handshake decode; grants are masked while reset is held.
    always_comb begin
        w_win = 1'b0;
        if (io_arb.req0_valid && io_arb.req1_valid) begin
            w_win = r_prio;
        end else if (io_arb.req1_valid) begin
            w_win = 1'b1;
        end else begin
            w_win = 1'b0;
        end
        w_grant0 = rst_n && (r_state == ST_IDLE) && io_arb.req0_valid && (w_win == 1'b0);
        w_grant1 = rst_n && (r_state == ST_IDLE) && io_arb.req1_valid && (w_win == 1'b1);
        w_accept = w_grant0 || w_grant1;
        w_rsp_hs = (r_state == ST_RESP) &&
                   (r_owner ? io_arb.rsp1_ready : io_arb.rsp0_ready);
    end

    // Response ports: only the owner sees the captured result, the other side reads zero.
    always_comb begin
        io_arb.rsp0_valid  = 1'b0;
        io_arb.rsp0_result = 32'd0;
        io_arb.rsp0_ovf    = 1'b0;
        io_arb.rsp1_valid  = 1'b0;
        io_arb.rsp1_result = 32'd0;
        io_arb.rsp1_ovf    = 1'b0;
        if (r_state == ST_RESP) begin
            if (r_owner) begin
                io_arb.rsp1_valid  = 1'b1;
                io_arb.rsp1_result = r_result;
                io_arb.rsp1_ovf    = r_ovf;
            end else begin
                io_arb.rsp0_valid  = 1'b1;
                io_arb.rsp0_result = r_result;
                io_arb.rsp0_ovf    = r_ovf;
            end
        end else begin
            io_arb.rsp0_valid = 1'b0;
            io_arb.rsp1_valid = 1'b0;
        end
    end

    assign io_arb.req0_ready = w_grant0;
    assign io_arb.req1_ready = w_grant1;
    assign io_arb.alu_a      = r_a;
    assign io_arb.alu_b      = r_b;
    assign io_arb.alu_shamt  = r_shamt;
    assign io_arb.alu_ctrl   = r_op;
    assign o_busy            = r_busy;
    assign o_ops_done        = r_ops_done;

    // Main FSM: latch the winning operation, capture the ALU output, then wait for the response handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_prio     <= RR_INIT;
            r_owner    <= 1'b0;
            r_a        <= 32'd0;
            r_b        <= 32'd0;
            r_shamt    <= 5'd0;
            r_op       <= 4'd0;
            r_result   <= 32'd0;
            r_ovf      <= 1'b0;
            r_busy     <= 1'b0;
            r_ops_done <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_owner <= w_grant1;
                        r_a     <= w_grant1 ? io_arb.req1_a     : io_arb.req0_a;
                        r_b     <= w_grant1 ? io_arb.req1_b     : io_arb.req0_b;
                        r_shamt <= w_grant1 ? io_arb.req1_shamt : io_arb.req0_shamt;
                        r_op    <= w_grant1 ? io_arb.req1_op    : io_arb.req0_op;
                        r_state <= ST_EXEC;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    // Codes 14/15 are undefined: never pass ALU garbage through.
                    r_result <= (r_op >= 4'd14) ? 32'd0 : io_arb.alu_result;
                    r_ovf    <= (r_op <= 4'd1) ? io_arb.alu_ovf : 1'b0;
                    r_state  <= ST_RESP;
                end
                ST_RESP: begin
                    if (w_rsp_hs) begin
                        r_state    <= ST_IDLE;
                        r_busy     <= 1'b0;
                        r_ops_done <= r_ops_done + 16'd1;
                        r_prio     <= ~r_owner;
                    end else begin
                        r_state <= ST_RESP;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a vector table of single operations on a reference ALU,
// plus hand-written contention, backpressure and reset-during-EXEC sequences.
module tb_alu_arbiter;
    logic        clk;
    logic        rst_n;
    logic        busy;
    logic [15:0] ops_done;
    int          checks;
    int          failures;
    int          exp_cnt;
    logic [31:0] m_res;
    logic        m_ovf;

    alu_arbiter_if ifc();

    alu_arbiter #(.RR_INIT(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .io_arb     (ifc.slave),
        .o_busy     (busy),
        .o_ops_done (ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU; reports overflow on every non-add/sub code and junk on 14/15 so masking is visible.
    always_comb begin
        m_res = 32'hDEADBEEF;
        m_ovf = 1'b1;
        case (ifc.alu_ctrl)
            4'd0: begin
                m_res = ifc.alu_a + ifc.alu_b;
                m_ovf = (ifc.alu_a[31] == ifc.alu_b[31]) && (m_res[31] != ifc.alu_a[31]);
            end
            4'd1: begin
                m_res = ifc.alu_a - ifc.alu_b;
                m_ovf = (ifc.alu_a[31] != ifc.alu_b[31]) && (m_res[31] != ifc.alu_a[31]);
            end
            4'd2:  m_res = ifc.alu_a & ifc.alu_b;
            4'd3:  m_res = ifc.alu_a | ifc.alu_b;
            4'd4:  m_res = ifc.alu_a ^ ifc.alu_b;
            4'd5:  m_res = ~(ifc.alu_a | ifc.alu_b);
            4'd6:  m_res = {31'd0, ($signed(ifc.alu_a) < $signed(ifc.alu_b))};
            4'd7:  m_res = {31'd0, (ifc.alu_a < ifc.alu_b)};
            4'd8:  m_res = ifc.alu_b << ifc.alu_shamt;
            4'd9:  m_res = ifc.alu_b >> ifc.alu_shamt;
            4'd10: m_res = 32'($signed(ifc.alu_b) >>> ifc.alu_shamt);
            4'd11: m_res = ifc.alu_b << ifc.alu_a[4:0];
            4'd12: m_res = ifc.alu_b >> ifc.alu_a[4:0];
            4'd13: m_res = 32'($signed(ifc.alu_b) >>> ifc.alu_a[4:0]);
            default: begin
                m_res = 32'hDEADBEEF;
                m_ovf = 1'b1;
            end
        endcase
    end
    assign ifc.alu_result = m_res;
    assign ifc.alu_ovf    = m_ovf;

    typedef struct {
        bit          port;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [3:0]  op;
        logic [31:0] res;
        logic        ovf;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic set_req(input bit p, input logic v, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh, input logic [3:0] op);
        if (p) begin
            ifc.req1_valid = v; ifc.req1_a = a; ifc.req1_b = b; ifc.req1_shamt = sh; ifc.req1_op = op;
        end else begin
            ifc.req0_valid = v; ifc.req0_a = a; ifc.req0_b = b; ifc.req0_shamt = sh; ifc.req0_op = op;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_cnt = 0;
    endtask

    // Called at posedge+1 with the arbiter idle; returns at posedge+1 after the response handshake.
    task automatic run_vec(input vec_t v);
        set_req(v.port, 1'b1, v.a, v.b, v.sh, v.op);
        @(negedge clk);
        chk("grant_owner", {31'd0, v.port ? ifc.req1_ready : ifc.req0_ready}, 32'd1);
        chk("grant_other", {31'd0, v.port ? ifc.req0_ready : ifc.req1_ready}, 32'd0);
        @(posedge clk); #1;
        set_req(v.port, 1'b0, 32'd0, 32'd0, 5'd0, 4'd0);
        @(negedge clk);
        chk("exec_alu_a", ifc.alu_a, v.a);
        chk("exec_alu_ctrl", {28'd0, ifc.alu_ctrl}, {28'd0, v.op});
        chk("exec_busy", {31'd0, busy}, 32'd1);
        chk("exec_no_rsp", {30'd0, ifc.rsp1_valid, ifc.rsp0_valid}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rsp_valid", {31'd0, v.port ? ifc.rsp1_valid : ifc.rsp0_valid}, 32'd1);
        chk("rsp_result", v.port ? ifc.rsp1_result : ifc.rsp0_result, v.res);
        chk("rsp_ovf", {31'd0, v.port ? ifc.rsp1_ovf : ifc.rsp0_ovf}, {31'd0, v.ovf});
        chk("rsp_other_zero", v.port ? ifc.rsp0_result : ifc.rsp1_result, 32'd0);
        if (v.port) ifc.rsp1_ready = 1'b1; else ifc.rsp0_ready = 1'b1;
        @(posedge clk); #1;
        ifc.rsp0_ready = 1'b0;
        ifc.rsp1_ready = 1'b0;
        exp_cnt++;
        chk("ops_done", {16'd0, ops_done}, exp_cnt);
        chk("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        checks = 0; failures = 0; exp_cnt = 0;
        vecs[0]  = '{1'b0, 32'd7,          32'd5,          5'd0, 4'd0,  32'd12,         1'b0};
        vecs[1]  = '{1'b1, 32'h7FFFFFFF,   32'd1,          5'd0, 4'd0,  32'h80000000,   1'b1};
        vecs[2]  = '{1'b1, 32'h7FFFFFFF,   32'd1,          5'd0, 4'd3,  32'h7FFFFFFF,   1'b0};
        vecs[3]  = '{1'b0, 32'd5,          32'd7,          5'd0, 4'd1,  32'hFFFFFFFE,   1'b0};
        vecs[4]  = '{1'b0, 32'h80000000,   32'd1,          5'd0, 4'd1,  32'h7FFFFFFF,   1'b1};
        vecs[5]  = '{1'b1, 32'hF0F0F0F0,   32'hFF00FF00,   5'd0, 4'd2,  32'hF000F000,   1'b0};
        vecs[6]  = '{1'b0, 32'hF0F0F0F0,   32'hFF00FF00,   5'd0, 4'd4,  32'h0FF00FF0,   1'b0};
        vecs[7]  = '{1'b1, 32'd0,          32'd0,          5'd0, 4'd5,  32'hFFFFFFFF,   1'b0};
        vecs[8]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          5'd0, 4'd6,  32'd1,          1'b0};
        vecs[9]  = '{1'b1, 32'hFFFFFFFF,   32'd1,          5'd0, 4'd7,  32'd0,          1'b0};
        vecs[10] = '{1'b0, 32'd0,          32'd1,          5'd4, 4'd8,  32'h00000010,   1'b0};
        vecs[11] = '{1'b1, 32'd0,          32'h80000000,   5'd4, 4'd9,  32'h08000000,   1'b0};
        vecs[12] = '{1'b0, 32'd0,          32'h80000000,   5'd4, 4'd10, 32'hF8000000,   1'b0};
        vecs[13] = '{1'b1, 32'd3,          32'd1,          5'd0, 4'd11, 32'h00000008,   1'b0};
        vecs[14] = '{1'b0, 32'd31,         32'h80000000,   5'd0, 4'd12, 32'h00000001,   1'b0};
        vecs[15] = '{1'b1, 32'd8,          32'h80000000,   5'd0, 4'd13, 32'hFF800000,   1'b0};
        vecs[16] = '{1'b0, 32'd1,          32'd1,          5'd0, 4'd15, 32'd0,          1'b0};
        vecs[17] = '{1'b1, 32'd1,          32'd1,          5'd0, 4'd14, 32'd0,          1'b0};

        rst_n = 1'b0;
        set_req(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 4'd0);
        set_req(1'b1, 1'b0, 32'd0, 32'd0, 5'd0, 4'd0);
        ifc.rsp0_ready = 1'b0;
        ifc.rsp1_ready = 1'b0;

        // Reset state, with a request already pending that must not be granted.
        ifc.req0_valid = 1'b1;
        #12;
        chk("rst_ready0", {31'd0, ifc.req0_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ops_done", {16'd0, ops_done}, 32'd0);
        chk("rst_alu_a", ifc.alu_a, 32'd0);
        chk("rst_rsp_valid", {30'd0, ifc.rsp1_valid, ifc.rsp0_valid}, 32'd0);
        ifc.req0_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            run_vec(vecs[i]);
        end

        // Contention: both requesters valid continuously from reset release.
        do_reset();
        ifc.rsp0_ready = 1'b1;
        ifc.rsp1_ready = 1'b1;
        set_req(1'b0, 1'b1, 32'd1,  32'd1,  5'd0, 4'd0);
        set_req(1'b1, 1'b1, 32'd10, 32'd20, 5'd0, 4'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rr_ready0", {31'd0, ifc.req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_ready1", {31'd0, ifc.req1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
            @(negedge clk);
            @(negedge clk);
            chk("rr_rsp_valid", {30'd0, ifc.rsp1_valid, ifc.rsp0_valid}, (k % 2 == 0) ? 32'd1 : 32'd2);
            chk("rr_rsp_result", (k % 2 == 0) ? ifc.rsp0_result : ifc.rsp1_result,
                (k % 2 == 0) ? 32'd2 : 32'd30);
        end
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 4'd0);
        set_req(1'b1, 1'b0, 32'd0, 32'd0, 5'd0, 4'd0);
        ifc.rsp0_ready = 1'b0;
        ifc.rsp1_ready = 1'b0;
        chk("rr_ops_done", {16'd0, ops_done}, 32'd4);

        // Backpressure on requester 0 while requester 1 waits.
        set_req(1'b0, 1'b1, 32'd100, 32'd23, 5'd0, 4'd0);
        @(negedge clk);
        chk("bp_ready0", {31'd0, ifc.req0_ready}, 32'd1);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 4'd0);
        set_req(1'b1, 1'b1, 32'd1, 32'd2, 5'd0, 4'd0);
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_rsp0_valid", {31'd0, ifc.rsp0_valid}, 32'd1);
            chk("bp_rsp0_result", ifc.rsp0_result, 32'd123);
            chk("bp_ready1_blocked", {31'd0, ifc.req1_ready}, 32'd0);
        end
        ifc.rsp0_ready = 1'b1;
        @(posedge clk); #1;
        ifc.rsp0_ready = 1'b0;
        @(negedge clk);
        chk("bp_ready1_after", {31'd0, ifc.req1_ready}, 32'd1);
        @(posedge clk); #1;
        set_req(1'b1, 1'b0, 32'd0, 32'd0, 5'd0, 4'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_rsp1_result", ifc.rsp1_result, 32'd3);
        ifc.rsp1_ready = 1'b1;
        @(posedge clk); #1;
        ifc.rsp1_ready = 1'b0;
        chk("bp_ops_done", {16'd0, ops_done}, 32'd6);

        // Reset asserted during EXEC discards the operation.
        do_reset();
        set_req(1'b0, 1'b1, 32'd2, 32'd3, 5'd0, 4'd0);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 4'd0);
        chk("mid_busy_exec", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_ops_done", {16'd0, ops_done}, 32'd0);
        chk("mid_alu_a", ifc.alu_a, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_req(1'b1, 1'b1, 32'd4, 32'd4, 5'd0, 4'd0);
        @(negedge clk);
        chk("post_rst_grant", {31'd0, ifc.req1_ready}, 32'd1);
        chk("post_rst_no_rsp", {30'd0, ifc.rsp1_valid, ifc.rsp0_valid}, 32'd0);
        @(posedge clk); #1;
        set_req(1'b1, 1'b0, 32'd0, 32'd0, 5'd0, 4'd0);
        @(negedge clk);
        chk("post_rst_exec_no_rsp", {30'd0, ifc.rsp1_valid, ifc.rsp0_valid}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_rst_rsp1", ifc.rsp1_result, 32'd8);
        ifc.rsp1_ready = 1'b1;
        @(posedge clk); #1;
        ifc.rsp1_ready = 1'b0;
        chk("post_rst_ops_done", {16'd0, ops_done}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter RR_INIT, default 0, is the requester index holding priority after reset.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-005 reqN_ready  output  1  requester N operation accepted this cycle.
REQ-006 reqN_a, reqN_b  input  32 each  operands A and B.
REQ-007 reqN_shamt  input  5  shift amount.
REQ-008 reqN_op  input  4  ALU control code, 0..13 (ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, SLLV, SRLV, SRAV).
REQ-009 rspN_valid  output  1  result pending for requester N.
REQ-010 rspN_ready  input  1  requester N takes the result.
REQ-011 rspN_result  output  32  result word.
REQ-012 rspN_ovf  output  1  signed-overflow flag.
REQ-013 alu_a, alu_b  output  32 each  operands to the shared ALU.
REQ-014 alu_shamt  output  5  shift amount to the ALU.
REQ-015 alu_ctrl  output  4  ALU control to the ALU.
REQ-016 alu_result  input  32  combinational ALU result.
REQ-017 alu_ovf  input  1  combinational ALU overflow.
REQ-018 busy  output  1  high whenever state is not IDLE.
REQ-019 ops_done  output  16  count of completed response handshakes.

Function
REQ-020 FSM states: IDLE, EXEC, RESP.
REQ-021 IDLE, no reqN_valid: remain in IDLE.
REQ-022 IDLE, exactly one reqN_valid: that requester wins.
REQ-023 IDLE, both valid: the priority holder wins.
REQ-024 Grant: the winner's reqN_ready is driven combinationally high in IDLE only; the loser's reqN_ready stays 0.
REQ-025 At accept: latch operands, shamt, op and owner index into registers, then go to EXEC.
REQ-026 alu_a, alu_b, alu_shamt, alu_ctrl are driven only from the latched registers, so they are stable throughout EXEC and hold their values outside EXEC.
REQ-027 In EXEC (one cycle): capture alu_result and alu_ovf into result registers, then go to RESP.
REQ-028 Ops 0 and 1: ovf equals the captured alu_ovf.
REQ-029 Ops 2..13: ovf is forced 0.
REQ-030 Ops 14 and 15: result is 0 and ovf is 0, regardless of the ALU inputs.
REQ-031 In RESP: only the owner's rspN_valid is 1; it carries the captured result and ovf, held stable until rspN_ready.
REQ-032 RESP with rsp_ready high: go to IDLE, ops_done increments (wraps 0xFFFF->0), priority passes to the other requester.
REQ-033 A new request cannot be accepted in the cycle of a RESP handshake.
REQ-034 Latency: accept at cycle t gives rsp_valid from cycle t+2; minimum spacing between accepts is 3 cycles.
REQ-035 Input changes or reqN_valid deassertion while not granted have no effect.
REQ-036 rspN_ready asserted while rspN_valid is 0 is ignored.
REQ-037 The non-owner's rsp outputs read 0.

Reset
REQ-038 On rst_n low, immediately: state IDLE, priority = RR_INIT, all reqN_ready/rspN_valid/ovf/result registers 0, alu_* outputs 0, ops_done 0, busy 0.
REQ-039 On reset mid-operation: the in-flight operation is discarded and no response is produced.
REQ-040 Reset release is synchronous to clk; the first grant is possible in the first cycle after release.

Verification
REQ-041 Single ADD: req0 a=7, b=5, op=0 -> ready0 at t; alu_a=7 during t+1; rsp0_valid at t+2 with result 12, ovf 0; ops_done becomes 1 after the handshake.
REQ-042 Overflow: req1 a=0x7FFFFFFF, b=1, op=0 -> rsp1_result 0x80000000, rsp1_ovf 1. Same operands with op=3 (OR) -> ovf 0.
REQ-043 Contention: both valid continuously after reset with RR_INIT=0 -> grants alternate 0,1,0,1; each response goes to the correct port.
REQ-044 Backpressure: rsp0_ready held 0 for 5 cycles -> rsp0_valid/result stable; req1 valid is not granted until the handshake.
REQ-045 Illegal op 15 with a=1, b=1 -> result 0, ovf 0. Separately, rst_n low during EXEC -> no rsp_valid, busy 0, and ops_done unchanged from reset value 0.
